// File: rtl/aer_in_fifo_if.sv
// AER input link + controller event port bundle for aer_in_fifo.
// slave = the FIFO front-end; master = link/controller side.
interface aer_in_fifo_if #(
  parameter int unsigned AW    = 17,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    AERIN_ADDR;
  logic             AERIN_REQ;
  logic             AERIN_ACK;
  logic             GATE_ACTIVITY;
  logic [AW-1:0]    EVT_ADDR;
  logic             EVT_VALID;
  logic             EVT_READY;
  logic [LW-1:0]    FIFO_LEVEL;
  logic             FIFO_FULL;
  logic [CNT_W-1:0] DROP_CNT;
  logic             DROP_CLR;

  modport slave (
    input  AERIN_ADDR, AERIN_REQ, GATE_ACTIVITY, EVT_READY, DROP_CLR,
    output AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_LEVEL, FIFO_FULL, DROP_CNT
  );

  modport master (
    output AERIN_ADDR, AERIN_REQ, GATE_ACTIVITY, EVT_READY, DROP_CLR,
    input  AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_LEVEL, FIFO_FULL, DROP_CNT
  );
endinterface

// File: rtl/aer_in_fifo.sv
// AER input front-end: REQ synchroniser, 4-phase handshake FSM and FWFT event FIFO
// with backpressure or drop-on-full behaviour and a saturating drop counter.
module aer_in_fifo #(
  parameter int unsigned AW          = 17,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DROP_MODE   = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           CLK,
  input  logic           RSTN,
  aer_in_fifo_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_LOW = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  logic [0:0]             state_q, state_d;
  logic                   ack_q, ack_d;
  logic [AW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   valid_q, valid_d, full_q, full_d;
  logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
  logic                   start_c, push_c, drop_c, pop_c;

  // Handshake decisions; full is taken from the registered flag, so a pop never frees space early.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.AERIN_REQ};
    req_s   = sync_q[SYNC_STAGES-1];
    start_c = (state_q == S_IDLE) && req_s && !bus.GATE_ACTIVITY;
    push_c  = start_c && !full_q;
    drop_c  = start_c && full_q && (DROP_MODE != 0);
    pop_c   = valid_q && bus.EVT_READY;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (push_c || drop_c) state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!req_s)           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_WAIT_LOW);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = bus.AERIN_ADDR;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = level_q + LW'(push_c) - LW'(pop_c);
    valid_d = (level_d != '0);
    full_d  = (level_d == LW'(DEPTH));
  end

  // Clear wins over a simultaneous drop; the count sticks at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.DROP_CLR) begin
      drop_cnt_d = '0;
    end else if (drop_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q     <= '0;
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.AERIN_ACK  = ack_q;
  assign bus.EVT_ADDR   = mem_q[rd_ptr_q];
  assign bus.EVT_VALID  = valid_q;
  assign bus.FIFO_LEVEL = level_q;
  assign bus.FIFO_FULL  = full_q;
  assign bus.DROP_CNT   = drop_cnt_q;
endmodule
